// File: rtl/bk_bus_pkg.sv
// bk_bus_pkg: shared definitions for vm1 bus responders on the CPU side of
// bkcore (timer, keyboard, roll).
//   - bus_st_e     : responder FSM state encoding
//   - OFS_*        : word offsets from a block's base address
//   - CB_*         : timer control register bit indices
//   - psel_div()   : prescaler divisor table, PRESCALE_BASE x {1,4,16,64}
package bk_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REPLY = 2'd2,
    ST_MISS  = 2'd3
  } bus_st_e;

  localparam logic [1:0] OFS_RELOAD = 2'd0;
  localparam logic [1:0] OFS_COUNT  = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;

  localparam int CB_RUN     = 0;
  localparam int CB_ONESHOT = 1;
  localparam int CB_EXP     = 2;
  localparam int CB_IE      = 3;
  localparam int CB_PSEL    = 4;  // two bits, 5:4
  localparam int CB_EXTSEL  = 6;

  function automatic logic [31:0] psel_div(input logic [1:0] psel,
                                           input logic [31:0] base);
    case (psel)
      2'd0:    return base;
      2'd1:    return base << 2;
      2'd2:    return base << 4;
      default: return base << 6;
    endcase
  endfunction

endpackage

// File: rtl/bk_bus_slave_fsm.sv
// bk_bus_slave_fsm: generic SYNC/DIN/DOUT/RPLY responder for a block of
// NWORDS consecutive words at BASE_ADDR.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   sync/din/dout/wtbt/addr   vm1 bus inputs
//   rdata             read data from the owning block (sampled on capture)
//   data_o, rply      bus read data / reply
//   sel               latched address hit
//   word_idx          latched address as a word index from BASE_ADDR
//   rd_strobe         one-cycle read capture strobe (REPLY entry with din)
//   wr_commit         one-cycle write commit (REPLY entry with dout, no din)
//   byte_en           byte lanes for the commit: 11 word, 01 low, 10 high
module bk_bus_slave_fsm
  import bk_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'o177706,
  parameter int          NWORDS      = 3,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  input  logic [15:0] addr,
  input  logic [15:0] rdata,
  output logic [15:0] data_o,
  output logic        rply,
  output logic        sel,
  output logic [1:0]  word_idx,
  output logic        rd_strobe,
  output logic        wr_commit,
  output logic [1:0]  byte_en
);

  localparam int WSW = 3;

  bus_st_e        st;
  logic           sync_d;
  logic [WSW-1:0] wcnt;
  logic           lane_hi;
  logic [14:0]    ofs_now;
  logic           hit_now;
  logic           serve;

  // Addresses below the base wrap to a large offset and miss.
  assign ofs_now = addr[15:1] - BASE_ADDR[15:1];
  assign hit_now = (ofs_now < 15'(NWORDS));

  // rply=0 in REPLY means the cycle has not been served yet; this makes
  // the strobes fire exactly once per bus cycle.
  assign serve     = (st == ST_REPLY) && sync && !rply;
  assign rd_strobe = serve && din;
  assign wr_commit = serve && dout && !din;
  assign byte_en   = wtbt ? (lane_hi ? 2'b10 : 2'b01) : 2'b11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      sync_d   <= 1'b0;
      wcnt     <= '0;
      lane_hi  <= 1'b0;
      sel      <= 1'b0;
      word_idx <= '0;
      rply     <= 1'b0;
      data_o   <= '0;
    end else begin
      sync_d <= sync;
      case (st)
        ST_IDLE: begin
          if (sync && !sync_d) begin
            sel      <= hit_now;
            word_idx <= ofs_now[1:0];
            lane_hi  <= addr[0];
            wcnt     <= WSW'(WAIT_STATES);
            st       <= hit_now ? ST_WAIT : ST_MISS;
          end
        end
        ST_WAIT: begin
          if (!sync)          st   <= ST_IDLE;
          else if (wcnt == 0) st   <= ST_REPLY;
          else                wcnt <= wcnt - 1'b1;
        end
        ST_REPLY: begin
          if (!sync) begin
            st     <= ST_IDLE;
            rply   <= 1'b0;
            data_o <= '0;
          end else if (!rply && (din || dout)) begin
            rply <= 1'b1;
            if (din) data_o <= rdata;
          end
        end
        ST_MISS: begin
          if (!sync) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bk_timer_resp.sv
// bk_timer_resp: vm1 bus responder for the system programmable timer
// (reload at BASE_ADDR, counter at +2, control at +4).
// Ports:
//   m_clock, reset_n    clock, async active-low reset
//   sync/din/dout/wtbt  bus handshake inputs; addr, data_i address/write data
//   data_o, rply, sel   read data, reply, latched address hit
//   irq                 registered EXP & IE
//   ext_tick            external tick input, only with BK_TIMER_EXTCLK_EN
// Control: bit0 RUN, bit1 ONESHOT, bit2 EXP (write 0 clears), bit3 IE,
//          bits5:4 PSEL, bit6 EXTSEL (only with BK_TIMER_EXTCLK_EN).
module bk_timer_resp
  import bk_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = 16'o177706,
  parameter int          WAIT_STATES   = 0,
  parameter logic [31:0] PRESCALE_BASE = 32
) (
  input  logic        m_clock,
  input  logic        reset_n,
  input  logic        sync,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  input  logic [15:0] addr,
  input  logic [15:0] data_i,
`ifdef BK_TIMER_EXTCLK_EN
  input  logic        ext_tick,
`endif
  output logic [15:0] data_o,
  output logic        rply,
  output logic        sel,
  output logic        irq
);

  logic [1:0]  widx;
  logic        rd_strobe, wr_commit;
  logic [1:0]  be;
  logic [15:0] rdata, ctrl_rd, reload_wr;
  logic [15:0] reload_q, cnt_q;
  logic        run_q, oneshot_q, exp_q, ie_q;
  logic [1:0]  psel_q;
  logic [31:0] presc_q, div;
  logic        presc_hit, tick, expire;
  logic        wr_reload, wr_ctrl, wr_ctrl_lo;

  bk_bus_slave_fsm #(
    .BASE_ADDR  (BASE_ADDR),
    .NWORDS     (3),
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk      (m_clock),
    .rst_n    (reset_n),
    .sync     (sync),
    .din      (din),
    .dout     (dout),
    .wtbt     (wtbt),
    .addr     (addr),
    .rdata    (rdata),
    .data_o   (data_o),
    .rply     (rply),
    .sel      (sel),
    .word_idx (widx),
    .rd_strobe(rd_strobe),
    .wr_commit(wr_commit),
    .byte_en  (be)
  );

  assign wr_reload  = wr_commit && (widx == OFS_RELOAD);
  assign wr_ctrl    = wr_commit && (widx == OFS_CTRL);
  assign wr_ctrl_lo = wr_ctrl && be[0];  // every control bit lives in the low byte
  assign reload_wr  = {be[1] ? data_i[15:8] : reload_q[15:8],
                       be[0] ? data_i[7:0]  : reload_q[7:0]};

  assign div       = psel_div(psel_q, PRESCALE_BASE);
  assign presc_hit = (presc_q == div - 32'd1);

`ifdef BK_TIMER_EXTCLK_EN
  logic       extsel_q;
  logic [2:0] ext_sr;
  logic       ext_pulse;

  // Two-flop synchroniser plus one stage for rising-edge detect.
  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) ext_sr <= '0;
    else          ext_sr <= {ext_sr[1:0], ext_tick};
  end
  assign ext_pulse = ext_sr[1] & ~ext_sr[2];
  assign tick      = run_q && (extsel_q ? ext_pulse : presc_hit);

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n)        extsel_q <= 1'b0;
    else if (wr_ctrl_lo) extsel_q <= data_i[CB_EXTSEL];
  end
`else
  assign tick = run_q && presc_hit;
`endif

  assign expire = tick && (cnt_q == 16'd0);

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CB_RUN]       = run_q;
    ctrl_rd[CB_ONESHOT]   = oneshot_q;
    ctrl_rd[CB_EXP]       = exp_q;
    ctrl_rd[CB_IE]        = ie_q;
    ctrl_rd[CB_PSEL+:2]   = psel_q;
`ifdef BK_TIMER_EXTCLK_EN
    ctrl_rd[CB_EXTSEL]    = extsel_q;
`endif
  end

  // Read data is only presented on the capture cycle; the FSM holds it.
  always_comb begin
    rdata = '0;
    if (rd_strobe) begin
      case (widx)
        OFS_RELOAD: rdata = reload_q;
        OFS_COUNT:  rdata = cnt_q;
        OFS_CTRL:   rdata = ctrl_rd;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      reload_q  <= '0;
      cnt_q     <= 16'hFFFF;
      run_q     <= 1'b0;
      oneshot_q <= 1'b0;
      exp_q     <= 1'b0;
      ie_q      <= 1'b0;
      psel_q    <= '0;
      presc_q   <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= exp_q & ie_q;

      if (!run_q || wr_ctrl || presc_hit) presc_q <= '0;
      else                                presc_q <= presc_q + 32'd1;

      // Reload changes only matter at the next wrap; nothing copies it early.
      if (wr_reload) reload_q <= reload_wr;

      // A written RUN value beats a one-shot expiry clearing it.
      if (wr_ctrl_lo) begin
        run_q     <= data_i[CB_RUN];
        oneshot_q <= data_i[CB_ONESHOT];
        ie_q      <= data_i[CB_IE];
        psel_q    <= data_i[CB_PSEL+:2];
      end else if (expire && oneshot_q) begin
        run_q <= 1'b0;
      end

      // Start (RUN 0->1) and ticking are exclusive: ticks need RUN=1.
      if (wr_ctrl_lo && data_i[CB_RUN] && !run_q)
        cnt_q <= reload_q;
      else if (tick)
        cnt_q <= (cnt_q != 16'd0) ? cnt_q - 16'd1 : (oneshot_q ? 16'd0 : reload_q);

      // Expiry set wins over a same-cycle clearing write.
      if (expire)                             exp_q <= 1'b1;
      else if (wr_ctrl_lo && !data_i[CB_EXP]) exp_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_timer_resp.sv
module tb_bk_timer_resp;

  localparam int          WS = 3;
  localparam int          PB = 4;
  localparam logic [15:0] A_RL  = 16'o177706;
  localparam logic [15:0] A_CNT = 16'o177710;
  localparam logic [15:0] A_CTL = 16'o177712;

  logic        m_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync = 1'b0, din = 1'b0, dout = 1'b0, wtbt = 1'b0;
  logic [15:0] addr = '0, data_i = '0;
  logic [15:0] data_o;
  logic        rply, sel, irq;
`ifdef BK_TIMER_EXTCLK_EN
  logic        ext_tick = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  // Counter model state: run started at edge c0 from reload rl_m.
  int   c0;
  int   rl_m;
  logic os_m;

  bk_timer_resp #(
    .BASE_ADDR    (16'o177706),
    .WAIT_STATES  (WS),
    .PRESCALE_BASE(PB)
  ) dut (
    .m_clock(m_clock),
    .reset_n(reset_n),
    .sync   (sync),
    .din    (din),
    .dout   (dout),
    .wtbt   (wtbt),
    .addr   (addr),
    .data_i (data_i),
`ifdef BK_TIMER_EXTCLK_EN
    .ext_tick(ext_tick),
`endif
    .data_o (data_o),
    .rply   (rply),
    .sel    (sel),
    .irq    (irq)
  );

  always #5 m_clock = ~m_clock;
  always @(posedge m_clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counter value after edge e, from the spec's tick rule.
  function automatic logic [15:0] ctr_at(input int e);
    int t;
    t = (e - c0) / PB;
    if (os_m) return (t >= rl_m) ? 16'd0 : 16'(rl_m - t);
    return 16'(rl_m - (t % (rl_m + 1)));
  endfunction

  // Called right after a negedge; returns right after a negedge.
  // redge = posedge count at which rply rose.
  task automatic bus_xfer(input string tag, input logic [15:0] a, input logic rd,
                          input logic wr, input logic bw, input logic [15:0] wd,
                          output int redge);
    int start;
    start = cyc;
    redge = -1;
    addr = a; wtbt = bw; data_i = wd; din = rd; dout = wr; sync = 1'b1;
    for (int i = 0; i < 20 && redge < 0; i++) begin
      @(negedge m_clock);
      if (rply) redge = cyc;
    end
    if (redge < 0) begin
      chk({tag, "_tmo"}, 32'd0, 32'd1);
      if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      chk({tag, "_lat"}, 32'(redge - start - 1), 32'(WS + 2));
      if (rd) begin
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk({tag, "_rd"}, {16'd0, data_o}, {16'd0, exp_q.pop_front()});
      end
    end
    sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0;
    @(negedge m_clock);
    chk({tag, "_rel"}, {15'd0, rply, data_o}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] ev);
    int r;
    exp_q.push_back(ev);
    bus_xfer(tag, a, 1'b1, 1'b0, 1'b0, 16'h0, r);
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d,
                    input logic bw, output int r);
    bus_xfer(tag, a, 1'b0, 1'b1, bw, d, r);
  endtask

  task automatic wait_irq(input string tag, input int exp_edge);
    int i;
    for (i = 0; i < 200 && !irq; i++) @(negedge m_clock);
    chk(tag, 32'(cyc), 32'(exp_edge));
  endtask

  initial begin
    int r, nr;

    repeat (3) @(negedge m_clock);
    chk("rst_out", {28'd0, rply, sel, irq, |data_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge m_clock);
    rd("rst_cnt", A_CNT, 16'hFFFF);
    rd("rst_ctl", A_CTL, 16'h0000);
    rd("rst_rl",  A_RL,  16'h0000);

    // Periodic: reload 8, RUN|IE.
    wr("w_rl8", A_RL, 16'o000010, 1'b0, r);
    rd("rl8", A_RL, 16'o000010);
    chk("sel_hit", {31'd0, sel}, 32'd1);
    wr("w_run", A_CTL, 16'o000011, 1'b0, r);
    c0 = r; rl_m = 8; os_m = 1'b0;
    rd("cnt_run", A_CNT, ctr_at(cyc + WS + 2));
    wait_irq("irq_per", c0 + 37);
    rd("ctl_exp", A_CTL, 16'o000015);
    rd("cnt_wrap", A_CNT, ctr_at(cyc + WS + 2));
    wr("w_stop", A_CTL, 16'o000000, 1'b0, r);
    rd("ctl_stop", A_CTL, 16'o000000);
    chk("irq_stop", {31'd0, irq}, 32'd0);

    // One-shot: reload 2, RUN|ONESHOT|IE.
    wr("w_rl2", A_RL, 16'o000002, 1'b0, r);
    wr("w_os", A_CTL, 16'o000013, 1'b0, r);
    c0 = r; rl_m = 2; os_m = 1'b1;
    wait_irq("irq_os", c0 + 13);
    rd("ctl_os", A_CTL, 16'o000016);
    repeat (10) @(negedge m_clock);
    rd("cnt_os", A_CNT, 16'd0);
    wr("w_clr", A_CTL, 16'o000012, 1'b0, r);
    rd("ctl_clr", A_CTL, 16'o000012);
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // Byte lanes.
    wr("w_bhi", 16'o177707, 16'hA5A5, 1'b1, r);
    rd("rl_bhi", A_RL, 16'hA502);
    wr("w_blo", 16'o177706, 16'h3C3C, 1'b1, r);
    rd("rl_blo", A_RL, 16'hA53C);

    // Counter is read-only but acknowledged.
    wr("w_cnt", A_CNT, 16'h1234, 1'b0, r);
    rd("cnt_ro", A_CNT, 16'd0);

    // Unmapped word: never replies.
    addr = 16'o177714; din = 1'b1; sync = 1'b1;
    nr = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge m_clock);
      if (rply) nr++;
    end
    chk("miss_rply", 32'(nr), 32'd0);
    chk("miss_sel", {31'd0, sel}, 32'd0);
    sync = 1'b0; din = 1'b0;
    @(negedge m_clock);
    rd("rl_miss", A_RL, 16'hA53C);

    // din and dout together: read wins, no write.
    exp_q.push_back(16'hA53C);
    bus_xfer("rdwr", A_RL, 1'b1, 1'b1, 1'b0, 16'h0000, r);
    rd("rl_rdwr", A_RL, 16'hA53C);

    // sync dropped during WAIT: no write.
    addr = A_RL; data_i = 16'h1111; dout = 1'b1; sync = 1'b1;
    repeat (2) @(negedge m_clock);
    sync = 1'b0; dout = 1'b0;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge m_clock);
      if (rply) nr++;
    end
    chk("abort_rply", 32'(nr), 32'd0);
    rd("rl_abort", A_RL, 16'hA53C);

    // Expiry tick coinciding with a write of RUN=0, EXP=0.
    wr("w_rl0", A_RL, 16'd0, 1'b0, r);
    wr("w_run0", A_CTL, 16'o000001, 1'b0, r);
    c0 = r;
    while ((cyc + WS + 3 - c0) % PB != 0) @(negedge m_clock);
    wr("w_race", A_CTL, 16'o000000, 1'b0, r);
    chk("race_edge", 32'((r - c0) % PB), 32'd0);
    rd("ctl_race", A_CTL, 16'o000004);
    wr("w_clr2", A_CTL, 16'o000000, 1'b0, r);
    rd("ctl_clr2", A_CTL, 16'o000000);

`ifdef BK_TIMER_EXTCLK_EN
    // External tick source: 4 pulses from reload 3 expire.
    wr("w_rl3", A_RL, 16'd3, 1'b0, r);
    wr("w_ext", A_CTL, 16'o000101, 1'b0, r);
    for (int i = 0; i < 4; i++) begin
      ext_tick = 1'b1; repeat (7) @(negedge m_clock);
      ext_tick = 1'b0; repeat (7) @(negedge m_clock);
    end
    rd("ctl_ext", A_CTL, 16'o000105);
    rd("cnt_ext", A_CNT, 16'd3);
`else
    wr("w_b6", A_CTL, 16'o000100, 1'b0, r);
    rd("ctl_b6", A_CTL, 16'o000000);
`endif

    // Reset in the middle of a reply.
    addr = A_CTL; din = 1'b1; sync = 1'b1;
    nr = 0;
    for (int i = 0; i < 20 && !rply; i++) @(negedge m_clock);
    chk("rst_pre", {31'd0, rply}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid", {15'd0, rply, data_o}, 32'd0);
    @(negedge m_clock);
    sync = 1'b0; din = 1'b0;
    @(negedge m_clock);
    reset_n = 1'b1;
    @(negedge m_clock);
    rd("rst2_cnt", A_CNT, 16'hFFFF);
    rd("rst2_rl", A_RL, 16'h0000);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bk_timer_resp.md
Name: bk_timer_resp

Overview:
- Bus responder for the vm1 SYNC/DIN/DOUT/WTBT/RPLY handshake, implementing the system programmable timer at 0177706, 0177710 and 0177712.
- Sits on the CPU side of bkcore, beside the keyboard/roll/initreg registers, and answers cycles that bkcore initiates.
- Provides a 16-bit down-counter with reload, prescaler, one-shot/periodic modes, an expiry flag and a level interrupt request.

Parameters:
- BASE_ADDR, 16'o177706: address of the reload register; the counter is at +2 and control at +4.
- WAIT_STATES, 0: extra m_clock cycles inserted between latching the cycle and asserting rply (0..7).
- PRESCALE_BASE, 32: m_clock cycles per timer tick when the prescaler select is 0.

Ports:
- m_clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sync  in  1  bus cycle active; its rising edge latches addr.
- din  in  1  read strobe.
- dout  in  1  write strobe.
- wtbt  in  1  byte operation.
- addr  in  16  bus address.
- data_i  in  16  write data; for odd byte writes it arrives already replicated into both halves.
- data_o  out  16  read data, valid while rply=1 on a read.
- rply  out  1  reply.
- sel  out  1  the latched address hits one of this block's 3 words.
- irq  out  1  interrupt request = EXP & IE.

Behaviour:
- Reset (asynchronous): rply=0, data_o=0, sel=0, irq=0, FSM=IDLE, reload=0, counter=16'hFFFF, control=0, prescaler=0.
- Address decode:
  - hit when addr[15:1] equals BASE_ADDR[15:1], +1 or +2.
  - Unmapped addresses never assert rply; bkcore's bad_addr/timeout path handles them.
- FSM:
  - IDLE: a 0→1 transition of sync latches addr and sel, then goes to WAIT. If sel=0, go to MISS instead.
  - WAIT: count WAIT_STATES cycles. At 0, go to REPLY after one cycle.
  - REPLY:
    - on din: drive data_o and assert rply, so latency from the sync edge is WAIT_STATES+2 cycles;
    - on dout: commit the write once, on the entry cycle, and assert rply;
    - hold rply until sync=0, then go to IDLE with rply=0 and data_o=0 in the same cycle.
  - MISS: stay until sync=0.
  - sync dropping in WAIT aborts to IDLE with no write.
  - din and dout both high: read wins, no write.
- Register map:
  - Reload: read/write, 16 bits.
  - Counter: read-only; writes are acknowledged and ignored.
  - Control:
    - bit0 RUN;
    - bit1 ONESHOT;
    - bit2 EXP, sticky; writing 0 clears it, writing 1 has no effect;
    - bit3 IE;
    - bits5:4 PSEL, tick divisor = PRESCALE_BASE × {1,4,16,64};
    - other bits read 0.
- Byte writes (wtbt=1) update only lane addr[0] (low or high byte).
- Prescaler:
  - counts only while RUN=1 and emits a one-cycle tick at the divisor;
  - cleared on any control write and whenever RUN=0.
- RUN transition 0→1 via write: counter loads reload in the same commit cycle.
- On each tick:
  - counter≠0: decrement;
  - counter=0: set EXP; ONESHOT=1 → clear RUN and hold 0; ONESHOT=0 → load reload.
- Reload writes while running take effect at the next wrap only.
- Simultaneous expiry and a write clearing EXP: set wins (EXP=1).
- Simultaneous expiry and a write of RUN=0: RUN=0 wins, EXP still sets.
- Counter reads return the current value registered on the REPLY entry cycle and held stable for the rest of the cycle.
- irq is registered and follows EXP&IE one cycle later.
- Reset asserted mid-cycle: rply drops immediately; the host retries.

Optional Feature:
- Macro: BK_TIMER_EXTCLK_EN.
- Defined:
  - adds input ext_tick (1 bit, synchronised by 2 flops on m_clock, rising edge detected);
  - control bit6 EXTSEL, when 1, replaces the prescaler tick with the ext_tick edge pulse;
  - PSEL is ignored while EXTSEL=1.
- Not defined: no ext_tick port, bit6 reads 0 and is not writable.

Decomposition:
- Shared package bk_bus_pkg:
  - FSM state encoding (IDLE, WAIT, REPLY, MISS);
  - register offsets;
  - control bit indices;
  - the PSEL divisor table.
- One sub-module, bk_bus_slave_fsm: a generic SYNC/DIN/DOUT/RPLY responder.
  - Outputs: latched address, rd_strobe, wr_commit (one cycle) and byte-lane enables.
  - Reusable for the keyboard and roll registers.
- Timer datapath stays in bk_timer_resp.

Test Plan:
- Write reload=16'o000010, then control=16'o000001 (PRESCALE_BASE=4, PSEL=0) → counter reads 8 immediately; after 36 cycles EXP=1; counter reloads to 8 and keeps running.
- ONESHOT (control=16'o000003, reload=2) → after 3 ticks EXP=1, RUN=0, counter holds 0; with IE=1, irq=1 one cycle after EXP.
- Byte write to 0177707 with data_i=16'hA5A5 and wtbt=1 → reload high byte=8'hA5, low byte unchanged; rply asserts WAIT_STATES+2 cycles after the sync rise.
- Access to 0177714 → rply stays 0 for the whole cycle; no register changes; sel=0.
- Write of EXP=0 in the same cycle as an expiry tick → EXP reads 1. sync dropped during WAIT (WAIT_STATES=3) → no write, FSM returns to IDLE.
- BK_TIMER_EXTCLK_EN, EXTSEL=1, reload=3 → 4 ext_tick pulses set EXP and the prescaler count is ignored; without the macro, bit6 reads 0 after writing 16'o000100.
